// File: rtl/id_ex_dm_core.sv
// ---------------------------------------------------------------------------
// id_ex_dm_core
//
// Single-cycle MIPS-style datapath slice covering decode, execute and data
// memory. It sits between instruction fetch and the write-back mux. The block
// decodes the instruction word, reads the register file, runs the ALU and
// accesses the data memory. It returns operands, the ALU result and the memory
// read data to the surrounding control and write-back logic.
//
// Parameters
//   DM_WORDS  data memory depth in 32-bit words (power of two)
//
// Ports
//   clk       in   1   register file and data memory write on the rising edge
//   rst_n     in   1   asynchronous active-low reset (clears the register file)
//   ins       in   32  current instruction word
//   wd        in   32  register write-back data from the WB mux
//   RegDst    in   1   1: destination is rd (ins[15:11]); 0: rt (ins[20:16])
//   RegWrite  in   1   register file write enable
//   ALUSrc    in   1   1: ALU B operand is imm; 0: rd2
//   op        in   3   ALU operation select
//   MemRead   in   1   data memory read enable
//   MemWrite  in   1   data memory write enable
//   rd1       out  32  reg[rs]
//   rd2       out  32  reg[rt]; also the store data
//   imm       out  32  sign-extended ins[15:0]
//   jTarget   out  26  ins[25:0]
//   z         out  32  ALU result; also the data memory byte address
//   zero      out  1   high when z is zero
//   memOut    out  32  data memory read data (0 when not reading)
//
// All outputs are combinational. Register and memory writes become visible
// after the next rising edge.
// ---------------------------------------------------------------------------
module id_ex_dm_core #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic [31:0] wd,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        ALUSrc,
  input  logic [2:0]  op,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] imm,
  output logic [25:0] jTarget,
  output logic [31:0] z,
  output logic        zero,
  output logic [31:0] memOut
);

  // Word-index width of the data memory.
  localparam int AW = $clog2(DM_WORDS);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // -------------------------------------------------------------------------
  // Instruction field decode
  // -------------------------------------------------------------------------
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_waddr;
  logic        w_unused_opcode;

  assign w_rs    = ins[25:21];
  assign w_rt    = ins[20:16];
  assign w_rd    = ins[15:11];
  assign w_waddr = RegDst ? w_rd : w_rt;

  // The opcode field is decoded by the control unit outside this block.
  assign w_unused_opcode = ^ins[31:26];

  assign imm     = {{16{ins[15]}}, ins[15:0]};
  assign jTarget = ins[25:0];

  // -------------------------------------------------------------------------
  // Register file: 32 x 32, two combinational read ports, one write port.
  // -------------------------------------------------------------------------
  logic [31:0] r_regs [32];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from before the edge; blocking here would let
  // one flop see another's new value within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (RegWrite && (w_waddr != 5'd0)) begin
      // $0 is hard-wired to zero, so writes to it are simply not performed.
      r_regs[w_waddr] <= wd;
    end
  end

  // Reads see the stored value, so a same-cycle read of the register being
  // written returns the old contents until the edge.
  assign rd1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
  assign rd2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;

  assign w_alu_b = ALUSrc ? imm : rd2;

  // NOTE: the result gets a default before the case so that no op value can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_alu_res = '0;
    case (op)
      ALU_AND: w_alu_res = rd1 & w_alu_b;
      ALU_OR:  w_alu_res = rd1 | w_alu_b;
      ALU_ADD: w_alu_res = rd1 + w_alu_b;
      ALU_SUB: w_alu_res = rd1 - w_alu_b;
      ALU_SLT: w_alu_res = {31'd0, ($signed(rd1) < $signed(w_alu_b))};
      default: w_alu_res = '0;
    endcase
  end

  assign z    = w_alu_res;
  assign zero = ~|w_alu_res;

  // -------------------------------------------------------------------------
  // Data memory: word addressed by z[AW+1:2]; byte offset z[1:0] is ignored.
  // Any address at or above 4*DM_WORDS is out of range: reads give 0 and
  // writes are dropped rather than aliasing onto a low word.
  // -------------------------------------------------------------------------
  logic [31:0]   r_mem [DM_WORDS];
  logic [AW-1:0] w_dm_index;
  logic          w_dm_in_range;

  assign w_dm_index    = z[AW+1:2];
  assign w_dm_in_range = (z[31:AW+2] == '0);

  // NOTE: the memory array has no reset branch; clearing it would force it
  // into discrete flops instead of a RAM macro, and its contents are defined
  // by software writes, not by rst_n.
  always_ff @(posedge clk) begin
    if (MemWrite && w_dm_in_range) begin
      r_mem[w_dm_index] <= rd2;
    end
  end

  // Asynchronous read: with MemRead and MemWrite both high, the old word is
  // shown until the edge commits the new one.
  assign memOut = (MemRead && w_dm_in_range) ? r_mem[w_dm_index] : '0;

endmodule

// File: tb/tb_id_ex_dm_core.sv
// ---------------------------------------------------------------------------
// tb_id_ex_dm_core
//
// Scoreboard bench for id_ex_dm_core. The driver applies one vector per clock
// cycle, shortly after the rising edge. It computes the expected outputs from
// a behavioural model (register array, memory array, arithmetic ALU) and
// pushes them into a queue. A separate monitor pops one entry on each falling
// edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_id_ex_dm_core;

  localparam int DM_WORDS = 1024;
  localparam int N_RANDOM = 400;

  logic        clk;
  logic        rst_n;
  logic [31:0] ins;
  logic [31:0] wd;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  op;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [25:0] jTarget;
  logic [31:0] z;
  logic        zero;
  logic [31:0] memOut;

  id_ex_dm_core #(.DM_WORDS(DM_WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ins      (ins),
    .wd       (wd),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrc   (ALUSrc),
    .op       (op),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .rd1      (rd1),
    .rd2      (rd2),
    .imm      (imm),
    .jTarget  (jTarget),
    .z        (z),
    .zero     (zero),
    .memOut   (memOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] ins;
    logic [31:0] wd;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src;
    logic [2:0]  op;
    logic        mem_read;
    logic        mem_write;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [31:0] z;
    logic        zero;
    logic [31:0] mem_out;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [DM_WORDS];
  int          checks;
  int          errors;
  int          vec_id;

  task automatic check(input string name, input int id,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=0x%08h expected=0x%08h", name, id, got, exp);
    end
  endtask

  // Reference ALU written straight from the operation table.
  function automatic logic [31:0] model_alu(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] itype(input int rs, input int rt, input logic [15:0] k);
    return {6'h08, 5'(rs), 5'(rt), k};
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h000};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] d,
                              input logic rdst, input logic rwr, input logic asrc,
                              input logic [2:0] f, input logic mrd, input logic mwr);
    vec_t v;
    v.rst_n     = 1'b1;
    v.ins       = i;
    v.wd        = d;
    v.reg_dst   = rdst;
    v.reg_write = rwr;
    v.alu_src   = asrc;
    v.op        = f;
    v.mem_read  = mrd;
    v.mem_write = mwr;
    return v;
  endfunction

  // Apply one vector, predict its outputs, then advance the model state by
  // the writes that the following rising edge will commit.
  task automatic drive(input vec_t v);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    @(posedge clk);
    #1;
    rst_n    = v.rst_n;
    ins      = v.ins;
    wd       = v.wd;
    RegDst   = v.reg_dst;
    RegWrite = v.reg_write;
    ALUSrc   = v.alu_src;
    op       = v.op;
    MemRead  = v.mem_read;
    MemWrite = v.mem_write;

    if (!v.rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end

    a         = m_regs[v.ins[25:21]];
    b         = m_regs[v.ins[20:16]];
    e.id      = vec_id;
    e.rd1     = a;
    e.rd2     = b;
    e.imm     = {{16{v.ins[15]}}, v.ins[15:0]};
    e.jt      = v.ins[25:0];
    e.z       = model_alu(v.op, a, v.alu_src ? e.imm : b);
    e.zero    = (e.z == 32'd0);
    e.mem_out = (v.mem_read && (e.z < 4 * DM_WORDS)) ? m_mem[e.z >> 2] : 32'd0;
    sb_q.push_back(e);

    if (v.rst_n && v.reg_write) begin
      dst = v.reg_dst ? v.ins[15:11] : v.ins[20:16];
      if (dst != 5'd0) m_regs[dst] = v.wd;
    end
    if (v.mem_write && (e.z < 4 * DM_WORDS)) m_mem[e.z >> 2] = b;
    vec_id++;
  endtask

  task automatic wr_reg(input int r, input logic [31:0] val);
    drive(mk(itype(0, r, 16'h0000), val, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0));
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rd1",     e.id, rd1,              e.rd1);
        check("rd2",     e.id, rd2,              e.rd2);
        check("imm",     e.id, imm,              e.imm);
        check("jTarget", e.id, {6'd0, jTarget},  {6'd0, e.jt});
        check("z",       e.id, z,                e.z);
        check("zero",    e.id, {31'd0, zero},    {31'd0, e.zero});
        check("memOut",  e.id, memOut,           e.mem_out);
      end
    end
  end

  initial begin : driver
    vec_t       v;
    logic [2:0] ops [8];
    checks = 0;
    errors = 0;
    vec_id = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < DM_WORDS; i++) m_mem[i] = '0;

    rst_n    = 1'b0;
    ins      = '0;
    wd       = '0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = 3'b000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: operands read zero while rst_n is low.
    v = mk(itype(8, 9, 16'h1234), 32'hDEAD, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    v.rst_n = 1'b0;
    drive(v);

    // Give the memory defined contents: store $0 to every word.
    for (int i = 0; i < DM_WORDS; i++) begin
      drive(mk(itype(0, 0, 16'(i * 4)), 32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1));
    end

    // Register write then read of reg 8.
    drive(mk(32'h20080005, 32'd5, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0));
    drive(mk(32'h01000000, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));

    // Writes to $0 are ignored.
    drive(mk(rtype(0, 0, 0), 32'd7, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0));
    drive(mk(rtype(0, 0, 0), 32'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0));

    // Operand set-up; each write also reads the old value of its own register.
    wr_reg(1, 32'd5);
    wr_reg(2, 32'd3);
    wr_reg(3, 32'd5);
    wr_reg(4, 32'hFFFF_FFFF);
    wr_reg(5, 32'd20);
    wr_reg(6, 32'h0000_1234);
    wr_reg(2, 32'd3);

    // ALU: every op code with A=5, B=3.
    ops = '{3'b010, 3'b110, 3'b001, 3'b000, 3'b111, 3'b011, 3'b100, 3'b101};
    foreach (ops[i]) begin
      drive(mk(rtype(1, 2, 0), 32'd0, 1'b0, 1'b0, 1'b0, ops[i], 1'b0, 1'b0));
    end
    drive(mk(rtype(1, 3, 0), 32'd0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0));  // 5-5 -> zero
    drive(mk(rtype(4, 2, 0), 32'd0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0));  // -1 < 3
    drive(mk(rtype(2, 4, 0), 32'd0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0));  // 3 < -1 false

    // Sign-extended immediate: 20 + (-4) = 16.
    drive(mk(itype(5, 0, 16'hFFFC), 32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0));

    // Memory store / load, byte offset ignored, read disabled, out of range.
    drive(mk(itype(0, 6, 16'd16),    32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1));
    drive(mk(itype(0, 0, 16'd16),    32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0));
    drive(mk(itype(0, 0, 16'd19),    32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0));
    drive(mk(itype(0, 0, 16'd16),    32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0));
    drive(mk(itype(0, 6, 16'h1000),  32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1));
    drive(mk(itype(0, 0, 16'h1000),  32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0));
    drive(mk(itype(0, 0, 16'h0000),  32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0));
    drive(mk(itype(0, 6, 16'h0FFC),  32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1));
    drive(mk(itype(0, 0, 16'h0FFC),  32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0));

    // Read and write together: old word until the edge, new word after.
    drive(mk(itype(0, 1, 16'd16),    32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1));
    drive(mk(itype(0, 0, 16'd16),    32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0));

    // Mid-run reset clears reg 8 and blocks a write while low.
    v = mk({6'h00, 5'd8, 5'd9, 16'h0000}, 32'hAA, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    v.rst_n = 1'b0;
    drive(v);
    drive(mk(rtype(8, 9, 0), 32'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0));
    drive(mk(rtype(1, 6, 0), 32'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0));

    // Randomized traffic; half the vectors aim at the memory window around
    // the top of the valid range.
    for (int n = 0; n < N_RANDOM; n++) begin
      v = mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        v.ins[25:21] = 5'd0;
        v.ins[15:0]  = 16'($urandom_range(0, 16'h1FFF));
        v.alu_src    = 1'b1;
        v.op         = 3'b010;
      end
      drive(v);
    end

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
